cm0_pmu_cdc_handshake_ctrl: RTL and testbench

Sequencer that shares one clock-domain-crossing request/acknowledge channel between several PMU-side requesters. It arbitrates round-robin, loads the winner's data word into CDC-safe launch registers, and runs a full four-phase handshake against an acknowledge returned from the remote domain. It signals completion back to the winning requester. It sits in the PMU between local power-control requesters and the remote-domain receiver.

---
 rtl/cm0_pmu_cdc_handshake_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cm0_pmu_cdc_handshake_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cm0_pmu_cdc_handshake_ctrl.sv
// Round-robin sequencer sharing one four-phase CDC request/acknowledge channel between
// several PMU requesters; outputs launch from reset-to-0 enable flops with no logic after them.

module cm0_pmu_cdc_send_reset (
   input  logic REGCLK,
   input  logic REGRESETn,
   input  logic REGEN,
   input  logic REGDI,
   output logic REGDO
);

   logic regdo_q;
   logic regdo_d;

   always_comb begin
      regdo_d = regdo_q;
      if (REGEN) regdo_d = REGDI;
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so every flop
   // samples the pre-edge value of its neighbours regardless of process ordering.
   always_ff @(posedge REGCLK or negedge REGRESETn) begin
      if (!REGRESETn) regdo_q <= 1'b0;
      else            regdo_q <= regdo_d;
   end

   assign REGDO = regdo_q;

endmodule

module cm0_pmu_cdc_handshake_ctrl #(
   parameter int NUM_REQ     = 2,
   parameter int DATA_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        REGCLK,
   input  logic                        REGRESETn,
   input  logic [NUM_REQ-1:0]          REQ_VALID,
   input  logic [NUM_REQ*DATA_W-1:0]   REQ_DATA,
   output logic [NUM_REQ-1:0]          REQ_DONE,
   output logic [NUM_REQ-1:0]          GRANT,
   output logic                        BUSY,
   input  logic                        CDC_ACK,
   output logic                        CDC_REQ,
   output logic [DATA_W-1:0]           CDC_DATA
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SET,
      ST_WAIT_HI,
      ST_CLR,
      ST_WAIT_LO,
      ST_DONE
   } state_e;

   state_e                   state_q,    state_d;
   logic [NUM_REQ-1:0]       grant_q,    grant_d;
   logic [PTR_W-1:0]         sel_q,      sel_d;
   logic [PTR_W-1:0]         ptr_q,      ptr_d;
   logic [SYNC_STAGES-1:0]   ack_sync_q, ack_sync_d;

   logic                     ack_s;
   logic                     any_valid;
   logic [PTR_W-1:0]         win_idx;
   logic [PTR_W-1:0]         next_ptr;
   logic                     data_en;
   logic                     req_en;
   logic                     req_di;
   logic [NUM_REQ-1:0]       req_done;
   logic [DATA_W-1:0]        load_data;

   // CDC_ACK feeds nothing but this chain.
   always_comb begin
      ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], CDC_ACK};
   end

   assign ack_s = ack_sync_q[SYNC_STAGES-1];

   // Descending scan so the last hit is the first valid requester at or after ptr_q.
   always_comb begin
      any_valid = 1'b0;
      win_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (REQ_VALID[idx]) begin
            any_valid = 1'b1;
            win_idx   = PTR_W'(idx);
         end
      end
      next_ptr = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
   end

   // NOTE: every variable gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      sel_d    = sel_q;
      ptr_d    = ptr_q;
      data_en  = 1'b0;
      req_en   = 1'b0;
      req_di   = 1'b0;
      req_done = '0;

      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               state_d          = ST_LOAD;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               sel_d            = win_idx;
               ptr_d            = next_ptr;
            end
         end
         ST_LOAD: begin
            data_en = 1'b1;
            state_d = ST_SET;
         end
         ST_SET: begin
            req_en  = 1'b1;
            req_di  = 1'b1;
            state_d = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            if (ack_s) state_d = ST_CLR;
         end
         ST_CLR: begin
            req_en  = 1'b1;
            req_di  = 1'b0;
            state_d = ST_WAIT_LO;
         end
         ST_WAIT_LO: begin
            if (!ack_s) state_d = ST_DONE;
         end
         ST_DONE: begin
            req_done = grant_q;
            grant_d  = '0;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge REGCLK or negedge REGRESETn) begin
      if (!REGRESETn) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         sel_q      <= '0;
         ptr_q      <= '0;
         ack_sync_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         sel_q      <= sel_d;
         ptr_q      <= ptr_d;
         ack_sync_q <= ack_sync_d;
      end
   end

   assign load_data = REQ_DATA[int'(sel_q)*DATA_W +: DATA_W];

   // Launch cells drive the ports directly; their enables are only high in LOAD/SET/CLR.
   cm0_pmu_cdc_send_reset u_req_cell (
      .REGCLK    (REGCLK),
      .REGRESETn (REGRESETn),
      .REGEN     (req_en),
      .REGDI     (req_di),
      .REGDO     (CDC_REQ)
   );

   for (genvar b = 0; b < DATA_W; b++) begin : g_data_cell
      cm0_pmu_cdc_send_reset u_data_cell (
         .REGCLK    (REGCLK),
         .REGRESETn (REGRESETn),
         .REGEN     (data_en),
         .REGDI     (load_data[b]),
         .REGDO     (CDC_DATA[b])
      );
   end

   assign REQ_DONE = req_done;
   assign GRANT    = grant_q;
   assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cm0_pmu_cdc_handshake_ctrl.sv
// Bench for cm0_pmu_cdc_handshake_ctrl: two instances (SYNC_STAGES 2 and 3), a remote ack
// model, requester drivers and a scoreboard of expected grant/data/latency per transfer.

module tb_cm0_pmu_cdc_handshake_ctrl;

   typedef struct packed {
      logic [1:0] grant;
      logic [3:0] data;
      logic [7:0] dly;
   } exp_t;

   logic                  clk;
   logic                  rst_n;
   logic [1:0][1:0]       req_valid;
   logic [1:0][7:0]       req_data;
   logic [1:0][1:0]       req_done;
   logic [1:0][1:0]       grant;
   logic [1:0]            busy;
   logic [1:0]            cdc_ack;
   logic [1:0]            cdc_req;
   logic [1:0][3:0]       cdc_data;

   int          n_tests = 0;
   int          n_fail  = 0;

   exp_t        sb_q [2][$];
   int          issued    [2][2];
   int          completed [2][2];
   logic [3:0]  rdata     [2][2];
   int          ack_dly   [2];
   int          acnt      [2];
   bit          toggle    [2];
   bit          phase     [2];
   int          dcnt      [2];

   int          cyc        [2];
   int          start      [2];
   bit          have       [2];
   exp_t        cur        [2];
   logic [1:0]  prev_grant [2];
   logic [1:0]  prev_done  [2];
   logic        prev_req   [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      cm0_pmu_cdc_handshake_ctrl #(
         .NUM_REQ     (2),
         .DATA_W      (4),
         .SYNC_STAGES (g + 2)
      ) u_dut (
         .REGCLK    (clk),
         .REGRESETn (rst_n),
         .REQ_VALID (req_valid[g]),
         .REQ_DATA  (req_data[g]),
         .REQ_DONE  (req_done[g]),
         .GRANT     (grant[g]),
         .BUSY      (busy[g]),
         .CDC_ACK   (cdc_ack[g]),
         .CDC_REQ   (cdc_req[g]),
         .CDC_DATA  (cdc_data[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Remote receiver: follows CDC_REQ after ack_dly extra half-cycle-aligned cycles.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (!rst_n) begin
            cdc_ack[g] = 1'b0;
            acnt[g]    = 0;
         end else if (cdc_req[g] != cdc_ack[g]) begin
            if (acnt[g] >= ack_dly[g]) begin
               cdc_ack[g] = cdc_req[g];
               acnt[g]    = 0;
            end else begin
               acnt[g]++;
            end
         end else begin
            acnt[g] = 0;
         end
      end
   end

   // Requesters: hold valid until REQ_DONE is seen, then drop for at least one cycle.
   always @(posedge clk) begin
      #1;
      for (int g = 0; g < 2; g++) begin
         logic [7:0] rd;
         rd = {rdata[g][1], rdata[g][0]};
         if (!rst_n) begin
            for (int r = 0; r < 2; r++) completed[g][r] = issued[g][r];
            req_valid[g] = '0;
            req_data[g]  = rd;
            dcnt[g]      = 0;
         end else begin
            for (int r = 0; r < 2; r++) begin
               if (req_done[g][r]) begin
                  req_valid[g][r] = 1'b0;
                  completed[g][r]++;
               end else begin
                  req_valid[g][r] = (issued[g][r] != completed[g][r]);
               end
            end
            if (toggle[g] && busy[g] && dcnt[g] >= 1) begin
               phase[g]    = ~phase[g];
               req_data[g] = rd ^ {8{phase[g]}};
            end else begin
               req_data[g] = rd;
            end
            dcnt[g] = busy[g] ? dcnt[g] + 1 : 0;
         end
      end
   end

   // Monitor: pops the scoreboard on each new grant and checks data, handshake timing and done.
   always @(posedge clk) begin
      #1;
      for (int g = 0; g < 2; g++) begin
         int s;
         int el;
         s = g + 2;
         if (!rst_n) begin
            have[g]       = 1'b0;
            prev_grant[g] = '0;
            prev_done[g]  = '0;
            prev_req[g]   = 1'b0;
            sb_q[g].delete();
         end else begin
            cyc[g]++;
            if (prev_done[g] != 0) begin
               check("done_pulse", 32'(req_done[g]), 32'(0));
               check("grant_clr", 32'(grant[g]), 32'(0));
               check("idle_after_done", 32'(busy[g]), 32'(0));
            end
            if (grant[g] != 0 && prev_grant[g] == 0) begin
               if (sb_q[g].size() == 0) begin
                  check("unexpected_grant", 32'(grant[g]), 32'(0));
               end else begin
                  cur[g]   = sb_q[g].pop_front();
                  have[g]  = 1'b1;
                  start[g] = cyc[g];
                  check("grant", 32'(grant[g]), 32'(cur[g].grant));
                  check("busy_on_grant", 32'(busy[g]), 32'(1));
               end
            end else if (prev_grant[g] != 0 && grant[g] != 0) begin
               check("grant_hold", 32'(grant[g]), 32'(prev_grant[g]));
            end
            if (have[g]) begin
               el = cyc[g] - start[g];
               if (el >= 1) check("data_hold", 32'(cdc_data[g]), 32'(cur[g].data));
               if (cdc_req[g] && !prev_req[g]) check("req_rise_lat", 32'(el), 32'(2));
               if (!cdc_req[g] && prev_req[g])
                  check("req_fall_lat", 32'(el), 32'(s + 4 + int'(cur[g].dly)));
               if (req_done[g] != 0) begin
                  check("done", 32'(req_done[g]), 32'(cur[g].grant));
                  check("done_lat", 32'(el), 32'(2*s + 5 + 2*int'(cur[g].dly)));
                  check("req_low_at_done", 32'(cdc_req[g]), 32'(0));
                  have[g] = 1'b0;
               end
            end else if (!busy[g]) begin
               check("req_idle", 32'(cdc_req[g]), 32'(0));
            end
            prev_grant[g] = grant[g];
            prev_done[g]  = req_done[g];
            prev_req[g]   = cdc_req[g];
         end
      end
   end

   task automatic push(input int g, input int r, input logic [3:0] d, input int dly);
      exp_t e;
      e.grant = 2'(1 << r);
      e.data  = d;
      e.dly   = 8'(dly);
      sb_q[g].push_back(e);
   endtask

   task automatic drain(input int g);
      int k;
      k = 0;
      while (k < 400 && (busy[g] || issued[g][0] != completed[g][0] ||
                         issued[g][1] != completed[g][1])) begin
         @(posedge clk);
         k++;
      end
      check("drain_timeout", 32'(k >= 400), 32'(0));
      repeat (2) @(posedge clk);
      check("sb_empty", 32'(sb_q[g].size()), 32'(0));
   endtask

   initial begin
      int k;
      for (int g = 0; g < 2; g++) begin
         ack_dly[g] = 0;
         toggle[g]  = 1'b0;
         phase[g]   = 1'b0;
         cyc[g]     = 0;
         for (int r = 0; r < 2; r++) begin
            issued[g][r]    = 0;
            completed[g][r] = 0;
            rdata[g][r]     = '0;
         end
      end
      req_valid = '0;
      req_data  = '0;
      rst_n     = 1'b1;
      #2 rst_n  = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) begin
         check("rst_busy", 32'(busy[g]), 32'(0));
         check("rst_grant", 32'(grant[g]), 32'(0));
         check("rst_done", 32'(req_done[g]), 32'(0));
         check("rst_cdc_req", 32'(cdc_req[g]), 32'(0));
         check("rst_cdc_data", 32'(cdc_data[g]), 32'(0));
      end
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Single transfer: requester 1, data 0xA, ack 3 cycles late.
      rdata[0][1] = 4'hA;
      ack_dly[0]  = 3;
      push(0, 1, 4'hA, 3);
      issued[0][1]++;
      drain(0);

      // Contention: pointer is back at 0, so grants go 0,1,0,1.
      rdata[0][0] = 4'h3;
      rdata[0][1] = 4'hC;
      ack_dly[0]  = 0;
      push(0, 0, 4'h3, 0);
      push(0, 1, 4'hC, 0);
      push(0, 0, 4'h3, 0);
      push(0, 1, 4'hC, 0);
      issued[0][0] += 2;
      issued[0][1] += 2;
      drain(0);

      // Stability: payload toggles every cycle once LOAD has passed.
      toggle[0]   = 1'b1;
      rdata[0][0] = 4'h5;
      ack_dly[0]  = 4;
      push(0, 0, 4'h5, 4);
      issued[0][0]++;
      drain(0);
      toggle[0] = 1'b0;

      // Reset in WAIT_HI: pointer is now 1; reset must abort and return it to 0.
      rdata[0][0] = 4'h9;
      ack_dly[0]  = 20;
      push(0, 0, 4'h9, 20);
      issued[0][0]++;
      k = 0;
      while (k < 50 && !cdc_req[0]) begin
         @(posedge clk);
         k++;
      end
      check("reset_setup_req", 32'(cdc_req[0]), 32'(1));
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("abort_cdc_req", 32'(cdc_req[0]), 32'(0));
      check("abort_cdc_data", 32'(cdc_data[0]), 32'(0));
      check("abort_busy", 32'(busy[0]), 32'(0));
      check("abort_grant", 32'(grant[0]), 32'(0));
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #2;
      check("post_rst_busy", 32'(busy[0]), 32'(0));
      check("post_rst_grant", 32'(grant[0]), 32'(0));

      rdata[0][0] = 4'h1;
      rdata[0][1] = 4'h2;
      ack_dly[0]  = 1;
      push(0, 0, 4'h1, 1);
      push(0, 1, 4'h2, 1);
      issued[0][0]++;
      issued[0][1]++;
      drain(0);

      // SYNC_STAGES=3: instant ack (12 cycles E0 to IDLE), then random ack delays.
      rdata[1][1] = 4'h6;
      ack_dly[1]  = 0;
      push(1, 1, 4'h6, 0);
      issued[1][1]++;
      drain(1);
      for (int t = 0; t < 6; t++) begin
         int r;
         int d;
         logic [3:0] v;
         r = t % 2;
         d = int'($urandom_range(0, 20));
         v = 4'($urandom_range(0, 15));
         rdata[1][r] = v;
         ack_dly[1]  = d;
         push(1, r, v, d);
         issued[1][r]++;
         drain(1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
